// File: rtl/imm_encode_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : imm_encode_packer_if
// Description : Request/response stream bundle for the immediate packer.
//               master = request producer / word consumer, slave = packer.
//               Signals: i_valid/o_ready request handshake, i_imm_sel,
//               i_imm, i_base, i_thread_index request payload; o_valid/i_ready
//               word handshake, o_instr, o_err, o_last, o_thread_index word
//               payload; o_err_count when BRISKI_IMM_ERRCNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface imm_encode_packer_if #(
    parameter int NUM_THREADS = 16
);
    localparam int TW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

    logic          i_valid;
    logic          o_ready;
    logic [3:0]    i_imm_sel;
    logic [31:0]   i_imm;
    logic [31:0]   i_base;
    logic [TW-1:0] i_thread_index;
    logic          o_valid;
    logic          i_ready;
    logic [31:0]   o_instr;
    logic          o_err;
    logic          o_last;
    logic [TW-1:0] o_thread_index;
`ifdef BRISKI_IMM_ERRCNT_EN
    logic [15:0]   o_err_count;
`endif

    modport master (
`ifdef BRISKI_IMM_ERRCNT_EN
        input  o_err_count,
`endif
        output i_valid, i_imm_sel, i_imm, i_base, i_thread_index, i_ready,
        input  o_ready, o_valid, o_instr, o_err, o_last, o_thread_index
    );

    modport slave (
`ifdef BRISKI_IMM_ERRCNT_EN
        output o_err_count,
`endif
        input  i_valid, i_imm_sel, i_imm, i_base, i_thread_index, i_ready,
        output o_ready, o_valid, o_instr, o_err, o_last, o_thread_index
    );
endinterface
`default_nettype wire

// File: rtl/imm_encode_packer.sv
`default_nettype none
// ============================================================================
// Module      : imm_encode_packer
// Description : Packs a 32-bit immediate into RV32I U/I/S/B/J instruction
//               fields of a base instruction, flags range/alignment/selector
//               errors, and expands the LI pseudo-op into LUI/ADDI (one or
//               two output words). Single registered output stage.
// Ports       : clk    - clock
//               rst_n  - asynchronous active-low reset
//               bus    - imm_encode_packer_if.slave request/word stream
// Options     : BRISKI_IMM_ERRCNT_EN adds a saturating 16-bit error counter
//               (bus.o_err_count).
// Revision    : 1.0 - initial release
// ============================================================================
module imm_encode_packer #(
    parameter int NUM_THREADS = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    imm_encode_packer_if.slave    bus
);
    localparam int TW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

    localparam logic [3:0] SEL_U  = 4'b0000;
    localparam logic [3:0] SEL_I  = 4'b0001;
    localparam logic [3:0] SEL_S  = 4'b0010;
    localparam logic [3:0] SEL_B  = 4'b0011;
    localparam logic [3:0] SEL_J  = 4'b0100;
    localparam logic [3:0] SEL_LI = 4'b0110;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        EMIT2 = 1'b1
    } state_t;

    state_t        state_q;
    logic          valid_q;
    logic          err_q;
    logic          last_q;
    logic [31:0]   instr_q;
    logic [31:0]   word2_q;
    logic [TW-1:0] tag_q;

    logic [31:0]   word1_d;
    logic [31:0]   word2_d;
    logic          err1_d;
    logic          two_d;

    wire logic [31:0] w_imm = bus.i_imm;
    wire logic [31:0] w_base = bus.i_base;
    wire logic [4:0]  w_rd = bus.i_base[11:7];
    // Sign-fit tests: all bits above the field's sign bit must equal it.
    wire logic w_fits12 = (&w_imm[31:11]) | ~(|w_imm[31:11]);
    wire logic w_fits13 = (&w_imm[31:12]) | ~(|w_imm[31:12]);
    wire logic w_fits21 = (&w_imm[31:20]) | ~(|w_imm[31:20]);
    // Upper part for LUI compensating the sign-extended ADDI low part.
    wire logic [19:0] w_hi = w_imm[31:12] + {19'd0, w_imm[11]};

    wire logic w_accept = bus.i_valid && bus.o_ready;

    always_comb begin
        word1_d = w_base;
        word2_d = 32'h0;
        err1_d  = 1'b0;
        two_d   = 1'b0;
        case (bus.i_imm_sel)
            SEL_U: begin
                word1_d = {w_imm[31:12], w_base[11:0]};
                err1_d  = |w_imm[11:0];
            end
            SEL_I: begin
                word1_d = {w_imm[11:0], w_base[19:0]};
                err1_d  = ~w_fits12;
            end
            SEL_S: begin
                word1_d = {w_imm[11:5], w_base[24:12], w_imm[4:0], w_base[6:0]};
                err1_d  = ~w_fits12;
            end
            SEL_B: begin
                word1_d = {w_imm[12], w_imm[10:5], w_base[24:12],
                           w_imm[4:1], w_imm[11], w_base[6:0]};
                err1_d  = w_imm[0] | ~w_fits13;
            end
            SEL_J: begin
                word1_d = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12],
                           w_base[11:0]};
                err1_d  = w_imm[0] | ~w_fits21;
            end
            SEL_LI: begin
                if (w_fits12) begin
                    word1_d = {w_imm[11:0], 5'd0, 3'b000, w_rd, 7'h13};
                end else if (w_imm[11:0] == 12'h000) begin
                    word1_d = {w_imm[31:12], w_rd, 7'h37};
                end else begin
                    word1_d = {w_hi, w_rd, 7'h37};
                    word2_d = {w_imm[11:0], w_rd, 3'b000, w_rd, 7'h13};
                    two_d   = 1'b1;
                end
            end
            default: begin
                word1_d = w_base;
                err1_d  = 1'b1;
            end
        endcase
    end

    assign bus.o_ready        = (state_q == IDLE) && (!valid_q || bus.i_ready);
    assign bus.o_valid        = valid_q;
    assign bus.o_instr        = instr_q;
    assign bus.o_err          = err_q;
    assign bus.o_last         = last_q;
    assign bus.o_thread_index = tag_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
            instr_q <= 32'h0;
            word2_q <= 32'h0;
            tag_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_accept) begin
                        valid_q <= 1'b1;
                        instr_q <= word1_d;
                        err_q   <= err1_d;
                        last_q  <= ~two_d;
                        tag_q   <= bus.i_thread_index;
                        word2_q <= word2_d;
                        if (two_d) begin
                            state_q <= EMIT2;
                        end
                    end else if (valid_q && bus.i_ready) begin
                        valid_q <= 1'b0;
                    end
                end
                EMIT2: begin
                    // Tag is left untouched so word 2 carries word 1's tag.
                    if (valid_q && bus.i_ready) begin
                        instr_q <= word2_q;
                        err_q   <= 1'b0;
                        last_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef BRISKI_IMM_ERRCNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 16'h0;
        end else if (w_accept && err1_d && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign bus.o_err_count = err_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imm_encode_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_encode_packer
// Description : Directed self-checking bench for imm_encode_packer with an
//               expected-word scoreboard. Honours BRISKI_IMM_ERRCNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_encode_packer;
    typedef struct {
        logic [31:0] instr;
        logic        err;
        logic        last;
        logic [3:0]  tag;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb_q[$];

    imm_encode_packer_if #(.NUM_THREADS(16)) bus ();

    imm_encode_packer #(.NUM_THREADS(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic expect_word(input logic [31:0] instr, input logic err,
                               input logic last, input logic [3:0] tag);
        exp_t e;
        e.instr = instr;
        e.err   = err;
        e.last  = last;
        e.tag   = tag;
        sb_q.push_back(e);
    endtask

    // Drives one request; returns the number of cycles until acceptance.
    task automatic send(input logic [3:0] sel, input logic [31:0] imm,
                        input logic [31:0] base, input logic [3:0] tag,
                        output int cyc);
        logic acc;
        bus.i_valid        = 1'b1;
        bus.i_imm_sel      = sel;
        bus.i_imm          = imm;
        bus.i_base         = base;
        bus.i_thread_index = tag;
        acc = 1'b0;
        cyc = 0;
        while (!acc && cyc < 40) begin
            @(negedge clk);
            acc = bus.o_ready;
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.i_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $error("FAIL send_timeout: observed no accept expected accept");
        end
    endtask

    function automatic logic [31:0] model_i(input logic [31:0] imm, input logic [31:0] base);
        return {imm[11:0], base[19:0]};
    endfunction

    // Scoreboard: every word handed over downstream is popped and compared.
    always @(negedge clk) begin
        if (rst_n && bus.o_valid && bus.i_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_word: observed %h expected none", bus.o_instr);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_instr", bus.o_instr, e.instr);
                check("sb_err", 32'(bus.o_err), 32'(e.err));
                check("sb_last", 32'(bus.o_last), 32'(e.last));
                check("sb_tag", 32'(bus.o_thread_index), 32'(e.tag));
            end
        end
    end

    initial begin
        int cyc;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_imm_sel = 4'h0;
        bus.i_imm = 32'h0;
        bus.i_base = 32'h0;
        bus.i_thread_index = 4'h0;
        bus.i_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        check("rst_valid", 32'(bus.o_valid), 32'h0);
        check("rst_instr", bus.o_instr, 32'h0);
        check("rst_err", 32'(bus.o_err), 32'h0);
        check("rst_last", 32'(bus.o_last), 32'h0);
        check("rst_tag", 32'(bus.o_thread_index), 32'h0);
        check("rst_ready", 32'(bus.o_ready), 32'h1);
`ifdef BRISKI_IMM_ERRCNT_EN
        check("rst_errcnt", 32'(bus.o_err_count), 32'h0);
`endif

        // I-type, latency 1
        expect_word(32'hFFF00013, 1'b0, 1'b1, 4'h1);
        send(4'b0001, 32'hFFFFFFFF, 32'h00000013, 4'h1, cyc);
        check("i_latency", 32'(bus.o_valid), 32'h1);
        check("i_accept_cycles", 32'(cyc), 32'h1);
        expect_word(32'h80000013, 1'b1, 1'b1, 4'h2);
        send(4'b0001, 32'd2048, 32'h00000013, 4'h2, cyc);
        expect_word(32'h80000013, 1'b0, 1'b1, 4'h3);
        send(4'b0001, 32'hFFFFF800, 32'h00000013, 4'h3, cyc);

        // U and S
        expect_word(32'h12345537, 1'b0, 1'b1, 4'h4);
        send(4'b0000, 32'h12345000, 32'h00000537, 4'h4, cyc);
        expect_word(32'h12345537, 1'b1, 1'b1, 4'h5);
        send(4'b0000, 32'h12345001, 32'h00000537, 4'h5, cyc);
        expect_word(32'hFE002C23, 1'b0, 1'b1, 4'h6);
        send(4'b0010, 32'hFFFFFFF8, 32'h00002023, 4'h6, cyc);

        // B / J
        expect_word(32'hFE000EE3, 1'b0, 1'b1, 4'h7);
        send(4'b0011, 32'hFFFFFFFC, 32'h00000063, 4'h7, cyc);
        expect_word(32'h0080006F, 1'b0, 1'b1, 4'h8);
        send(4'b0100, 32'd8, 32'h0000006F, 4'h8, cyc);
        expect_word(32'h00000363, 1'b1, 1'b1, 4'h9);
        send(4'b0011, 32'd7, 32'h00000063, 4'h9, cyc);

        // Unsupported selector
        expect_word(32'hDEADBEEF, 1'b1, 1'b1, 4'hA);
        send(4'b0101, 32'h0, 32'hDEADBEEF, 4'hA, cyc);

        // LI two-word
        expect_word(32'h123462B7, 1'b0, 1'b0, 4'hB);
        expect_word(32'hFFF28293, 1'b0, 1'b1, 4'hB);
        send(4'b0110, 32'h12345FFF, 32'h00000280, 4'hB, cyc);
        check("li2_last0", 32'(bus.o_last), 32'h0);
        check("li2_ready0", 32'(bus.o_ready), 32'h0);

        // LI single-word
        expect_word(32'h000122B7, 1'b0, 1'b1, 4'hC);
        send(4'b0110, 32'h00012000, 32'h00000280, 4'hC, cyc);
        expect_word(32'h06400293, 1'b0, 1'b1, 4'hD);
        send(4'b0110, 32'd100, 32'h00000280, 4'hD, cyc);

        // Backpressure
        repeat (3) @(posedge clk);
        #1;
        bus.i_ready = 1'b0;
        expect_word(32'h12300013, 1'b0, 1'b1, 4'h9);
        send(4'b0001, 32'h00000123, 32'h00000013, 4'h9, cyc);
        repeat (5) begin
            @(negedge clk);
            check("bp_instr", bus.o_instr, 32'h12300013);
            check("bp_valid", 32'(bus.o_valid), 32'h1);
            check("bp_flags", {30'd0, bus.o_err, bus.o_last}, 32'h1);
            check("bp_tag", 32'(bus.o_thread_index), 32'h9);
            check("bp_ready", 32'(bus.o_ready), 32'h0);
        end
        @(posedge clk);
        #1;
        bus.i_ready = 1'b1;
        for (int t = 3; t < 16; t += 4) begin
            logic [31:0] imm;
            imm = 32'(t * 37) - 32'd200;
            expect_word(model_i(imm, 32'h00000093), 1'b0, 1'b1, 4'(t));
            send(4'b0001, imm, 32'h00000093, 4'(t), cyc);
            check("b2b_cycles", 32'(cyc), 32'h1);
        end

        // Reset while EMIT2 holds the ADDI word
        repeat (3) @(posedge clk);
        #1;
        expect_word(32'h123462B7, 1'b0, 1'b0, 4'h6);
        send(4'b0110, 32'h12345FFF, 32'h00000280, 4'h6, cyc);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("emit2_rst_valid", 32'(bus.o_valid), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("emit2_no_word", 32'(bus.o_valid), 32'h0);
        end
        check("emit2_sb_empty", 32'(sb_q.size()), 32'h0);
        @(posedge clk);
        #1;

`ifdef BRISKI_IMM_ERRCNT_EN
        check("errcnt_cleared", 32'(bus.o_err_count), 32'h0);
        expect_word(32'h80000013, 1'b1, 1'b1, 4'h1);
        send(4'b0001, 32'd2048, 32'h00000013, 4'h1, cyc);
        expect_word(32'h00000363, 1'b1, 1'b1, 4'h2);
        send(4'b0011, 32'd7, 32'h00000063, 4'h2, cyc);
        expect_word(32'h00000000, 1'b0, 1'b1, 4'h3);
        send(4'b0001, 32'd0, 32'h00000000, 4'h3, cyc);
        expect_word(32'h00000017, 1'b1, 1'b1, 4'h4);
        send(4'b1111, 32'd0, 32'h00000017, 4'h4, cyc);
        check("errcnt_three", 32'(bus.o_err_count), 32'h3);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("errcnt_reset", 32'(bus.o_err_count), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
`endif

        // Drain whatever is left, bounded
        for (int k = 0; k < 20 && sb_q.size() != 0; k++) begin
            @(posedge clk);
        end
        check("final_sb_empty", 32'(sb_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/imm_encode_packer.md
Name: imm_encode_packer

Overview:
- Inverse of the decode-stage immediate selector/sign-extender: takes a 32-bit immediate value, a format selector and a base instruction, and packs the immediate into the RV32I instruction fields.
- Checks that the immediate is in range and correctly aligned, and expands a load-immediate pseudo-op into LUI/ADDI.
- Sits in the per-core instruction-injection path: debug/boot loader → packer → instruction-memory write port.
- Valid/ready stream in and out; the thread index is carried with each request.

Parameters:
- NUM_THREADS, 16, number of hardware threads; sets the thread-tag width as $clog2(NUM_THREADS).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  request valid
- o_ready  out  1  request accepted when i_valid && o_ready
- i_imm_sel  in  4  0000 U, 0001 I, 0010 S, 0011 B, 0100 J, 0110 LI pseudo; all other codes unsupported
- i_imm  in  32  immediate value; byte offset for B and J
- i_base  in  32  base instruction; the non-immediate bits are kept
- i_thread_index  in  $clog2(NUM_THREADS)  tag
- o_valid  out  1  output word valid
- i_ready  in  1  downstream ready
- o_instr  out  32  packed instruction
- o_err  out  1  request had a range, alignment or selector error
- o_last  out  1  final word of the request
- o_thread_index  out  $clog2(NUM_THREADS)  tag echoed from the request

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. On reset: o_valid=0, o_instr=0, o_err=0, o_last=0, o_thread_index=0, FSM=IDLE.
- FSM states:
  - IDLE: o_ready = !o_valid || i_ready. On accept, the output register loads word 1 and o_valid=1 the next cycle (latency 1).
    - LI needing two words → go to EMIT2 and hold the second word internally; o_last=0 on word 1.
    - Otherwise o_last=1.
  - EMIT2: o_ready=0. When o_valid && i_ready, load word 2 with o_last=1, o_err=0 and the same thread tag, then return to IDLE.
- Output hold: o_instr, o_err, o_last and o_thread_index hold stable while o_valid && !i_ready.
- Throughput: in IDLE, a new request is accepted in the same cycle the current word drains, giving one word per cycle.
- Packing (all bits not listed are taken from i_base):
  - U: [31:12]=imm[31:12]. err if imm[11:0]!=0.
  - I: [31:20]=imm[11:0]. err if imm is not in [-2048, 2047].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0]. Same range as I.
  - B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1]. err if imm[0]==1 or imm is not in [-4096, 4094].
  - J: [31]=imm[20], [19:12]=imm[19:12], [20]=imm[11], [30:21]=imm[10:1]. err if imm[0]==1 or imm is not in [-2^20, 2^20-2].
  - On error, the truncated encoding is still emitted, with o_err=1.
- LI (rd = i_base[11:7]; lo = imm[11:0]; hi = (imm + 32'h800)[31:12], wrap-around ignored):
  - imm in [-2048, 2047]: one word, ADDI rd,x0,imm = {lo, 5'd0, 3'b000, rd, 7'h13}.
  - Else if lo==0: one word, LUI = {imm[31:12], rd, 7'h37}.
  - Else: two words, {hi, rd, 7'h37} then {lo, rd, 3'b000, rd, 7'h13}.
  - LI never raises o_err.
- Unsupported selector: o_instr = i_base, o_err=1, o_last=1.
- Reset during EMIT2: the pending second word is discarded. After rst_n releases, the FSM is in IDLE with o_valid=0.
- Outputs depend only on registered state; there is no combinational path from i_valid to o_valid.

Optional Feature:
- Macro: BRISKI_IMM_ERRCNT_EN
- Defined:
  - Adds output o_err_count, 16 bits, reset to 0.
  - Increments by 1 on each accepted request that produces o_err=1, counted at the output-register load.
  - Saturates at 16'hFFFF.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- I-type: base 32'h00000013, imm 32'hFFFFFFFF, sel 0001 → o_instr 32'hFFF00013, o_err 0, o_last 1, o_valid one cycle after accept. Same request with imm 2048 → o_err 1.
- B/J: sel 0011, base 32'h00000063, imm -4 → 32'hFE000EE3. sel 0100, base 32'h0000006F, imm 8 → 32'h0080006F. B with imm 6+1=7 → o_err 1.
- LI two-word: base rd=5 (32'h00000280), imm 32'h12345FFF → 32'h123462B7 (o_last 0), then 32'hFFF28293 (o_last 1); o_ready stays 0 between the two words.
- LI single-word: imm 32'h00012000 → one word 32'h000122B7 (LUI). imm 100 → one ADDI word 32'h06400293.
- Backpressure: hold i_ready=0 for 5 cycles with a word pending → o_instr and flags stable, o_ready=0. Then i_ready=1 with back-to-back requests → one word per cycle, thread tags preserved in order.
- Reset in EMIT2: assert rst_n=0 after the LUI word → o_valid drops immediately and no ADDI word follows. With BRISKI_IMM_ERRCNT_EN defined, 3 erroring requests give o_err_count=3, and reset clears it to 0.
